// File: rtl/stream_spill_fifo.sv
`default_nettype none
// ============================================================================
// stream_spill_fifo : valid/ready elastic buffer, optional fall-through
// Rev 1.0
// ============================================================================
module stream_spill_fifo #(
  parameter int unsigned DataWidth        = 32,
  parameter int unsigned Depth            = 2,
  parameter bit          FallThrough      = 1'b0,
  parameter int unsigned AlmostFullThresh = Depth - 1,
  parameter int unsigned UsageWidth       = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DataWidth-1:0]  data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DataWidth-1:0]  data_o,
  output logic [UsageWidth-1:0] usage_o,
  output logic                  almost_full_o
);

  localparam int unsigned           c_ptr_width = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [UsageWidth-1:0] c_count_max = UsageWidth'(Depth);
  localparam logic [UsageWidth-1:0] c_count_one = UsageWidth'(1);
  localparam logic [UsageWidth-1:0] c_af_thresh = UsageWidth'(AlmostFullThresh);
  localparam logic [c_ptr_width-1:0] c_ptr_last = c_ptr_width'(Depth - 1);
  localparam logic [c_ptr_width-1:0] c_ptr_one  = c_ptr_width'(1);

  if (Depth == 0) begin : g_depth_check
    $error("stream_spill_fifo: Depth must be at least 1");
  end

  logic [DataWidth-1:0]   mem_q [Depth];
  logic [c_ptr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [UsageWidth-1:0]  count_q, count_d;
  logic empty, full, bypass_mode, push, pop, write_en, read_en;

  function automatic logic [c_ptr_width-1:0] ptr_inc(input logic [c_ptr_width-1:0] ptr);
    return (ptr == c_ptr_last) ? '0 : ptr + c_ptr_one;
  endfunction

  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == c_count_max);
    bypass_mode = FallThrough && empty;
    // ready_o depends only on stored state and flush, never on ready_i
    ready_o     = ~full & ~flush_i;
    if (bypass_mode) begin
      valid_o = valid_i & ~flush_i;
      data_o  = data_i;
    end else begin
      valid_o = ~empty & ~flush_i;
      data_o  = mem_q[rd_ptr_q];
    end
    push     = valid_i & ready_o & ~flush_i;
    pop      = valid_o & ready_i & ~flush_i;
    // a fall-through beat consumed in the same cycle never touches storage
    write_en = push & ~(bypass_mode & pop);
    read_en  = pop & ~bypass_mode;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (write_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (read_en)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({write_en, read_en})
        2'b10:   count_d = count_q + c_count_one;
        2'b01:   count_d = count_q - c_count_one;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (write_en) mem_q[wr_ptr_q] <= data_i;
  end

  assign usage_o       = count_q;
  assign almost_full_o = (count_q >= c_af_thresh);

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= c_count_max);

  a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !flush_i) |=> (flush_i || ($stable(valid_o) && $stable(data_o))));

  a_in_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_o && !flush_i) |=> (flush_i || (valid_i && $stable(data_i))));

  if (!FallThrough) begin : g_no_ft_check
    a_no_valid_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(valid_o && empty));
  end
`endif

endmodule
`default_nettype wire
